// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline/memory side and the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the view of the pipeline and memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and load/store.
// One transaction outstanding at a time; data side wins unless fetch has been starved
// for STARVE_MAX consecutive data grants. A taken branch kills a pending or in-flight fetch.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] LAT_END    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_I,
        S_RD_D,
        S_WR_D
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  w_lat_cnt_nxt;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_nxt;
    logic        r_kill;
    logic        w_kill_nxt;

    logic        w_if_ok;
    logic        w_if_gnt;
    logic        w_dm_gnt;
    logic        w_if_valid;
    logic        w_dm_valid;
    logic [31:0] w_if_rdata;
    logic [31:0] w_dm_rdata;
    logic        w_mem_en;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;

    // A fetch that is being flushed this cycle is never eligible for a grant.
    assign w_if_ok = bus.if_req & ~bus.if_flush;

    // Next-state and output decode: arbitration in IDLE, latency tracking while busy.
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_kill_nxt    = r_kill;
        w_if_gnt      = 1'b0;
        w_dm_gnt      = 1'b0;
        w_if_valid    = 1'b0;
        w_dm_valid    = 1'b0;
        w_if_rdata    = '0;
        w_dm_rdata    = '0;
        w_mem_en      = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.dm_req && !((r_starve_cnt == STARVE_LIM) && w_if_ok)) begin
                    w_dm_gnt      = 1'b1;
                    w_mem_en      = 1'b1;
                    w_mem_we      = bus.dm_we;
                    w_mem_addr    = bus.dm_addr;
                    w_mem_wdata   = bus.dm_wdata;
                    w_state_nxt   = bus.dm_we ? S_WR_D : S_RD_D;
                    w_lat_cnt_nxt = 4'd1;
                end else if (w_if_ok) begin
                    w_if_gnt      = 1'b1;
                    w_mem_en      = 1'b1;
                    w_mem_addr    = bus.if_addr;
                    w_state_nxt   = S_RD_I;
                    w_lat_cnt_nxt = 4'd1;
                    w_kill_nxt    = 1'b0;
                end
            end
            S_RD_I: begin
                if (r_lat_cnt == LAT_END) begin
                    w_state_nxt   = S_IDLE;
                    w_lat_cnt_nxt = 4'd0;
                    w_kill_nxt    = 1'b0;
                    if (!(r_kill || bus.if_flush)) begin
                        w_if_valid = 1'b1;
                        w_if_rdata = bus.mem_rdata;
                    end
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 4'd1;
                    if (bus.if_flush) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end
            S_RD_D: begin
                if (r_lat_cnt == LAT_END) begin
                    w_state_nxt   = S_IDLE;
                    w_lat_cnt_nxt = 4'd0;
                    w_dm_valid    = 1'b1;
                    w_dm_rdata    = bus.mem_rdata;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 4'd1;
                end
            end
            S_WR_D: begin
                w_state_nxt   = S_IDLE;
                w_lat_cnt_nxt = 4'd0;
                w_dm_valid    = 1'b1;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_lat_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Starvation counter: counts data grants that jumped a waiting fetch, saturating at the limit.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!bus.if_req || w_if_gnt) begin
            w_starve_nxt = 4'd0;
        end else if (w_dm_gnt && (r_starve_cnt < STARVE_LIM)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    // State registers; reset abandons any in-flight read so its late data is ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_kill       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_kill       <= w_kill_nxt;
        end
    end

    // All outputs forced low while reset is held.
    assign bus.if_gnt    = i_rst_n & w_if_gnt;
    assign bus.dm_gnt    = i_rst_n & w_dm_gnt;
    assign bus.if_valid  = i_rst_n & w_if_valid;
    assign bus.dm_valid  = i_rst_n & w_dm_valid;
    assign bus.if_rdata  = i_rst_n ? w_if_rdata  : '0;
    assign bus.dm_rdata  = i_rst_n ? w_dm_rdata  : '0;
    assign bus.mem_en    = i_rst_n & w_mem_en;
    assign bus.mem_we    = i_rst_n & w_mem_we;
    assign bus.mem_addr  = i_rst_n ? w_mem_addr  : '0;
    assign bus.mem_wdata = i_rst_n ? w_mem_wdata : '0;
    assign bus.stall_f   = i_rst_n & bus.if_req & ~w_if_valid;
    assign bus.stall_m   = i_rst_n & bus.dm_req & ~w_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// The model tracks only who owns the memory and the absolute cycle its transaction completes.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int N_CYCLES   = 4000;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nErrors;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester and reset bookkeeping.
    bit          ifPending;
    logic [31:0] ifAddr;
    bit          dmPending;
    bit          dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    int          rstLeft;

    // Reference model: owner 0 none, 1 fetch, 2 load, 3 store.
    int  cyc;
    int  owner;
    int  doneCycle;
    bit  killed;
    int  starve;
    int  nIfGrants;
    int  nDmGrants;
    int  nForced;

    logic        eIfGnt, eDmGnt, eIfValid, eDmValid, eMemEn, eMemWe, eStallF, eStallM;
    logic [31:0] eIfRdata, eDmRdata, eMemAddr, eMemWdata;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of legal random requester, flush, reset and memory activity.
    task automatic applyStimulus();
        int dmProb;
        dmProb = ((cyc / 500) % 2 == 1) ? 95 : 40;
        if (rstLeft > 0) begin
            rst_n   = 1'b0;
            rstLeft = rstLeft - 1;
        end else if (cyc > 20 && $urandom_range(0, 199) == 0) begin
            rst_n   = 1'b0;
            rstLeft = $urandom_range(0, 2);
        end else begin
            rst_n = 1'b1;
        end
        if (!ifPending && $urandom_range(0, 99) < 50) begin
            ifPending = 1'b1;
            ifAddr    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        end
        if (!dmPending && $urandom_range(0, 99) < dmProb) begin
            dmPending = 1'b1;
            dmWe      = ($urandom_range(0, 99) < 30);
            dmAddr    = $urandom;
            dmWdata   = $urandom;
        end
        bus.if_flush  = ($urandom_range(0, 99) < (ifPending ? 6 : 2));
        bus.if_req    = ifPending;
        bus.if_addr   = ifAddr;
        bus.dm_req    = dmPending;
        bus.dm_we     = dmWe;
        bus.dm_addr   = dmAddr;
        bus.dm_wdata  = dmWdata;
        bus.mem_rdata = $urandom;
    endtask

    // Compute this cycle's expected outputs from the current inputs, then advance the model.
    task automatic modelStep();
        bit ifOk;
        eIfGnt = 0; eDmGnt = 0; eIfValid = 0; eDmValid = 0;
        eMemEn = 0; eMemWe = 0; eStallF = 0; eStallM = 0;
        eIfRdata = '0; eDmRdata = '0; eMemAddr = '0; eMemWdata = '0;
        if (!rst_n) begin
            owner     = 0;
            killed    = 0;
            starve    = 0;
            ifPending = 0;
            dmPending = 0;
            return;
        end
        ifOk = bus.if_req && !bus.if_flush;
        if (owner != 0) begin
            if (owner == 1 && bus.if_flush) killed = 1;
            if (cyc == doneCycle) begin
                if (owner == 1 && !killed) begin
                    eIfValid = 1;
                    eIfRdata = bus.mem_rdata;
                end else if (owner == 2) begin
                    eDmValid = 1;
                    eDmRdata = bus.mem_rdata;
                end else if (owner == 3) begin
                    eDmValid = 1;
                end
                owner  = 0;
                killed = 0;
            end
        end else if (bus.dm_req && !(starve == STARVE_MAX && ifOk)) begin
            eDmGnt    = 1;
            eMemEn    = 1;
            eMemWe    = bus.dm_we;
            eMemAddr  = bus.dm_addr;
            eMemWdata = bus.dm_wdata;
            owner     = bus.dm_we ? 3 : 2;
            doneCycle = cyc + (bus.dm_we ? 1 : MEM_LAT);
            nDmGrants++;
        end else if (ifOk) begin
            eIfGnt    = 1;
            eMemEn    = 1;
            eMemAddr  = bus.if_addr;
            owner     = 1;
            killed    = 0;
            doneCycle = cyc + MEM_LAT;
            nIfGrants++;
            if (bus.dm_req) nForced++;
        end
        if (!bus.if_req || eIfGnt) starve = 0;
        else if (eDmGnt) starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
        eStallF = bus.if_req && !eIfValid;
        eStallM = bus.dm_req && !eDmValid;
        if (eIfValid || bus.if_flush) ifPending = 0;
        if (eDmValid) dmPending = 0;
    endtask

    initial begin
        nChecks = 0; nErrors = 0; cyc = 0;
        owner = 0; doneCycle = 0; killed = 0; starve = 0;
        nIfGrants = 0; nDmGrants = 0; nForced = 0;
        ifPending = 0; dmPending = 0; rstLeft = 2;
        ifAddr = '0; dmWe = 0; dmAddr = '0; dmWdata = '0;
        rst_n = 1'b0;
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            modelStep();
            checkOutput("if_gnt",    32'(bus.if_gnt),   32'(eIfGnt));
            checkOutput("dm_gnt",    32'(bus.dm_gnt),   32'(eDmGnt));
            checkOutput("if_valid",  32'(bus.if_valid), 32'(eIfValid));
            checkOutput("dm_valid",  32'(bus.dm_valid), 32'(eDmValid));
            checkOutput("if_rdata",  bus.if_rdata,      eIfRdata);
            checkOutput("dm_rdata",  bus.dm_rdata,      eDmRdata);
            checkOutput("mem_en",    32'(bus.mem_en),   32'(eMemEn));
            checkOutput("mem_we",    32'(bus.mem_we),   32'(eMemWe));
            checkOutput("mem_addr",  bus.mem_addr,      eMemAddr);
            checkOutput("mem_wdata", bus.mem_wdata,     eMemWdata);
            checkOutput("stall_f",   32'(bus.stall_f),  32'(eStallF));
            checkOutput("stall_m",   32'(bus.stall_m),  32'(eStallM));
            cyc++;
        end
        $display("[TB] grants if=%0d dm=%0d forced_if=%0d", nIfGrants, nDmGrants, nForced);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
